mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port RAM controller and arbiter between the instruction fetch path (InstCache) and the load/store execution path (ALU_LS behind the LSBuffer). It owns the byte-wide RAM/IO port: it grants one requester at a time, serialises 1/2/4-byte transactions into byte accesses, assembles read data little-endian and returns it with a one-cycle ack. A misprediction flush aborts in-flight reads; stores always complete.

## Interface
- No parameters. `DataWidth` (32) and the size/state encodings come from the shared defines.
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  when low, no new grant is made; an in-flight transaction still completes
- flush  in  1  ROB misprediction clear; aborts an in-flight read
- mem_din  in  8  RAM/IO read byte, valid one cycle after its address was driven
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  UART buffer full; blocks writes to IO space
- IC_req_valid  in  1  fetch request; held with IC_addr stable until IC_ack
- IC_addr  in  32  word fetch address
- IC_ack  out  1  one-cycle pulse; IC_data valid in this cycle
- IC_data  out  32  fetched instruction
- LS_req_valid  in  1  load/store request; held with the fields below stable until LS_ack
- LS_is_store  in  1  1 = store
- LS_size  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes
- LS_addr  in  32  byte address
- LS_wdata  in  32  store data; the low N bytes are used
- LS_ack  out  1  one-cycle pulse; LS_rdata is valid in this cycle for loads
- LS_rdata  out  32  load data, zero-extended; sign extension is done by ALU_LS

## Operation
- States:
  - IDLE: grant allowed.
  - READ
  - WRITE
  - WAIT_IO: store to IO space blocked by io_buffer_full.
  - DONE: ack cycle, no grant.
- Arbitration in IDLE, when rdy=1 and flush=0:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that did not win the last grant.
  - Grant latches the owner, the base address, the byte count N (1, 2 or 4; IC is always 4) and the write data.
  - Grant clears the byte counter (3 bits).
- Address and data rules:
  - Byte k address = base + k, modulo 2^32.
  - A read byte captured for index k is placed in bits [8k+7:8k].
  - Unused upper bytes are 0.
- IO space: address[17:16] == 2'b11.
  - A store to IO space with io_buffer_full=1 enters WAIT_IO, holding mem_wr=0 and mem_a=0.
  - It issues once io_buffer_full=0.
- Flush:
  - In READ or at grant: the next state is IDLE, no ack, mem_wr=0, and the partial data is discarded.
  - In WRITE or WAIT_IO: the transaction runs to completion and acks.
  - A request valid in the flush cycle is not granted that cycle.
- While idle or reading, mem_wr=0, mem_a=0 when idle, and mem_dout=0 when not writing.

## Timing
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, IC_ack=0, LS_ack=0, IC_data=0, LS_rdata=0. State is IDLE and the last winner is IC, so LS wins the first tie.
- Outputs are registered. With grant made in cycle G:
  - Read of N bytes:
    - Addresses are driven in cycles G+1 .. G+N.
    - Bytes are captured in cycles G+2 .. G+N+1.
    - Ack is high in cycle G+N+2, which is the DONE state.
    - A word fetch takes 6 cycles from grant to ack.
  - Write of N bytes:
    - mem_wr=1 with address/byte in cycles G+1 .. G+N.
    - Ack is high in cycle G+N+1, which is the DONE state.
    - WAIT_IO cycles add to this latency.
- DONE always lasts exactly one cycle, then IDLE.
  - The requester deasserts valid on the edge ending the ack cycle.
  - The earliest next grant is in the cycle after DONE.
- Ack data stays stable until the next ack from the same requester.
- rdy=0 only suppresses grants in IDLE.

## Structure
- Shared defines (existing defines file):
  - `True`/`False`, `DataWidth`.
  - Size codes (SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10).
  - IO address-select constant.
  - State encoding for IDLE/READ/WRITE/WAIT_IO/DONE.
  - Owner encoding (OWN_IC, OWN_LS).
- No sub-module: the arbiter, the byte serialiser and the assembler are a single FSM of about 200 lines.

## Test plan
- IC fetch at 0x00000004 with RAM bytes 13 00 00 00 -> mem_a 4,5,6,7 in consecutive cycles; IC_ack 6 cycles after grant with IC_data=0x00000013.
- IC and LS (load word, 0x100) valid in the same cycle after reset -> LS granted first; IC granted in the cycle after LS_ack's DONE; the next tie goes to LS.
- LS store half 0xBEEF at 0x1FF -> mem_wr=1 at 0x1FF with byte EF, then 0x200 with byte BE; LS_ack 3 cycles after grant; mem_wr=0 afterward.
- LS store byte 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0 for those 5 cycles; the write issues in the first cycle after full drops; ack follows.
- Flush 2 cycles into an IC fetch -> no IC_ack; IDLE next; the IC re-request is granted normally. Flush during a 4-byte store -> all 4 bytes written, LS_ack issued.
- Assert rst low mid-read -> all outputs 0 immediately (asynchronous); after release, the first tie goes to LS.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants, size/state/owner encodings and helpers for the RAM controller.
package mem_ctrl_pkg;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam int unsigned DataWidth = 32;

  localparam logic [1:0] SizeB = 2'b00;
  localparam logic [1:0] SizeH = 2'b01;
  localparam logic [1:0] SizeW = 2'b10;

  // address[17:16] value that selects the IO space
  localparam logic [1:0] IoSel = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StWaitIo,
    StDone
  } state_e;

  typedef enum logic {
    OwnIc,
    OwnLs
  } owner_e;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    logic [2:0] len;
    case (size)
      SizeB:   len = 3'd1;
      SizeH:   len = 3'd2;
      SizeW:   len = 3'd4;
      default: len = 3'd4;
    endcase
    return len;
  endfunction

  function automatic logic is_io(input logic [DataWidth-1:0] addr);
    return addr[17:16] == IoSel;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port arbiter between instruction fetch and load/store, serialising
// 1/2/4-byte transactions and assembling read data little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [DataWidth-1:0] mem_a,
  output logic                 mem_wr,
  input  logic                 io_buffer_full,
  input  logic                 IC_req_valid,
  input  logic [DataWidth-1:0] IC_addr,
  output logic                 IC_ack,
  output logic [DataWidth-1:0] IC_data,
  input  logic                 LS_req_valid,
  input  logic                 LS_is_store,
  input  logic [1:0]           LS_size,
  input  logic [DataWidth-1:0] LS_addr,
  input  logic [DataWidth-1:0] LS_wdata,
  output logic                 LS_ack,
  output logic [DataWidth-1:0] LS_rdata
);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  owner_e               last_q, last_d;
  logic [DataWidth-1:0] base_q, base_d;
  logic [2:0]           len_q, len_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] buf_q, buf_d;
  logic [DataWidth-1:0] mem_a_q, mem_a_d;
  logic [7:0]           mem_dout_q, mem_dout_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 ic_ack_q, ic_ack_d;
  logic [DataWidth-1:0] ic_data_q, ic_data_d;
  logic                 ls_ack_q, ls_ack_d;
  logic [DataWidth-1:0] ls_rdata_q, ls_rdata_d;

  logic                 ic_win, ls_win, grant;
  logic [DataWidth-1:0] req_addr, next_addr, issue_addr;
  logic [2:0]           req_len, next_idx;
  logic [1:0]           cap_idx;

  // On a tie the requester that lost the previous grant wins.
  assign ic_win     = IC_req_valid && (!LS_req_valid || (last_q == OwnLs));
  assign ls_win     = LS_req_valid && (!IC_req_valid || (last_q == OwnIc));
  assign grant      = rdy && !flush && (ic_win || ls_win);
  assign req_addr   = ic_win ? IC_addr : LS_addr;
  assign req_len    = ic_win ? 3'd4 : size_len(LS_size);
  assign next_idx   = cnt_q + 3'd1;
  assign next_addr  = base_q + DataWidth'(next_idx);
  assign issue_addr = base_q + DataWidth'(cnt_q);
  // mem_din in this cycle belongs to the address issued one cycle earlier
  assign cap_idx    = 2'(cnt_q - 3'd1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ic_ack_d   = False;
    ls_ack_d   = False;
    ic_data_d  = ic_data_q;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      StIdle: begin
        mem_a_d    = '0;
        mem_wr_d   = False;
        mem_dout_d = '0;
        if (grant) begin
          owner_d = ic_win ? OwnIc : OwnLs;
          last_d  = owner_d;
          base_d  = req_addr;
          len_d   = req_len;
          cnt_d   = '0;
          buf_d   = '0;
          wdata_d = ic_win ? '0 : LS_wdata;
          if (ls_win && LS_is_store) begin
            if (is_io(req_addr) && io_buffer_full) begin
              state_d = StWaitIo;
            end else begin
              state_d    = StWrite;
              mem_wr_d   = True;
              mem_a_d    = req_addr;
              mem_dout_d = LS_wdata[7:0];
            end
          end else begin
            state_d = StRead;
            mem_a_d = req_addr;
          end
        end
      end

      StRead: begin
        if (flush) begin
          state_d = StIdle;
          mem_a_d = '0;
          buf_d   = '0;
        end else begin
          if (cnt_q != 3'd0) begin
            buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == len_q) begin
            state_d = StDone;
            mem_a_d = '0;
            if (owner_q == OwnIc) begin
              ic_ack_d  = True;
              ic_data_d = buf_d;
            end else begin
              ls_ack_d   = True;
              ls_rdata_d = buf_d;
            end
          end else begin
            cnt_d   = next_idx;
            mem_a_d = (next_idx < len_q) ? next_addr : '0;
          end
        end
      end

      StWrite: begin
        if (next_idx < len_q) begin
          cnt_d = next_idx;
          if (is_io(next_addr) && io_buffer_full) begin
            state_d    = StWaitIo;
            mem_wr_d   = False;
            mem_a_d    = '0;
            mem_dout_d = '0;
          end else begin
            mem_a_d    = next_addr;
            mem_dout_d = wdata_q[{next_idx[1:0], 3'b000} +: 8];
          end
        end else begin
          state_d    = StDone;
          mem_wr_d   = False;
          mem_a_d    = '0;
          mem_dout_d = '0;
          ls_ack_d   = True;
        end
      end

      StWaitIo: begin
        mem_wr_d   = False;
        mem_a_d    = '0;
        mem_dout_d = '0;
        if (!io_buffer_full) begin
          state_d    = StWrite;
          mem_wr_d   = True;
          mem_a_d    = issue_addr;
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      owner_q    <= OwnIc;
      last_q     <= OwnIc;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= False;
      ic_ack_q   <= False;
      ic_data_q  <= '0;
      ls_ack_q   <= False;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ic_ack_q   <= ic_ack_d;
      ic_data_q  <= ic_data_d;
      ls_ack_q   <= ls_ack_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign IC_ack   = ic_ack_q;
  assign IC_data  = ic_data_q;
  assign LS_ack   = ls_ack_q;
  assign LS_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array RAM model predicts fetch/load data and the
// write byte stream; directed timing scenarios followed by randomized contention traffic.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        IC_req_valid;
  logic [31:0] IC_addr, IC_data;
  logic        IC_ack;
  logic        LS_req_valid, LS_is_store, LS_ack;
  logic [1:0]  LS_size;
  logic [31:0] LS_addr, LS_wdata, LS_rdata;

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush          (flush),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .IC_req_valid   (IC_req_valid),
    .IC_addr        (IC_addr),
    .IC_ack         (IC_ack),
    .IC_data        (IC_data),
    .LS_req_valid   (LS_req_valid),
    .LS_is_store    (LS_is_store),
    .LS_size        (LS_size),
    .LS_addr        (LS_addr),
    .LS_wdata       (LS_wdata),
    .LS_ack         (LS_ack),
    .LS_rdata       (LS_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct packed {
    logic        st;
    logic [31:0] d;
  } ls_t;

  logic [31:0] ic_q[$];
  ls_t         ls_q[$];
  wr_t         wr_q[$];

  logic [7:0]  ram   [0:65535];
  logic [7:0]  model [0:65535];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int wr_cyc = 0;
  bit rand_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical RAM: read byte is valid the cycle after its address; IO space is not backed.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr && (mem_a[17:16] != 2'b11)) ram[mem_a[15:0]] <= mem_dout;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an ack or a write byte.
  always @(negedge clk) begin
    if (IC_ack) begin
      if (ic_q.size() == 0) fail_now("ic_unexpected_ack");
      else check32("ic_data", IC_data, ic_q.pop_front());
    end
    if (LS_ack) begin
      if (ls_q.size() == 0) fail_now("ls_unexpected_ack");
      else begin
        ls_t e;
        e = ls_q.pop_front();
        if (!e.st) check32("ls_rdata", LS_rdata, e.d);
      end
    end
    if (mem_wr) begin
      wr_cyc = cyc;
      if (wr_q.size() == 0) fail_now("unexpected_write");
      else begin
        wr_t w;
        w = wr_q.pop_front();
        check32("write_addr", mem_a, w.a);
        check32("write_byte", {24'h0, mem_dout}, {24'h0, w.d});
      end
    end else begin
      check32("dout_when_not_writing", {24'h0, mem_dout}, 32'h0);
    end
  end

  task automatic ic_fetch(input logic [31:0] a, output int t0, output int t1);
    logic [31:0] e;
    for (int k = 0; k < 4; k++) e[8*k +: 8] = model[16'(a + 32'(k))];
    ic_q.push_back(e);
    @(posedge clk); #1;
    IC_addr = a;
    IC_req_valid = 1'b1;
    t0 = cyc;
    t1 = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (IC_ack) begin
        t1 = cyc;
        break;
      end
    end
    if (t1 < 0) fail_now("ic_ack_timeout");
    @(posedge clk); #1;
    IC_req_valid = 1'b0;
  endtask

  task automatic ls_op(input logic st, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output int t0, output int t1);
    int n;
    logic [31:0] e;
    logic [31:0] ba;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    e = 32'h0;
    for (int k = 0; k < n; k++) begin
      ba = a + 32'(k);
      if (st) begin
        wr_q.push_back('{a: ba, d: wd[8*k +: 8]});
        if (ba[17:16] != 2'b11) model[ba[15:0]] = wd[8*k +: 8];
      end else begin
        e[8*k +: 8] = model[ba[15:0]];
      end
    end
    ls_q.push_back('{st: st, d: e});
    @(posedge clk); #1;
    LS_is_store = st;
    LS_size = sz;
    LS_addr = a;
    LS_wdata = wd;
    LS_req_valid = 1'b1;
    t0 = cyc;
    t1 = -1;
    for (int m = 0; m < 300; m++) begin
      @(negedge clk);
      if (LS_ack) begin
        t1 = cyc;
        break;
      end
    end
    if (t1 < 0) fail_now("ls_ack_timeout");
    @(posedge clk); #1;
    LS_req_valid = 1'b0;
  endtask

  task automatic tie_round(input logic [31:0] ic_a);
    int i0, i1, l0, l1;
    fork
      ic_fetch(ic_a, i0, i1);
      ls_op(1'b0, 2'b10, 32'h100, 32'h0, l0, l1);
    join
    check32("tie_ls_first_latency", 32'(l1 - l0), 32'd6);
    check32("tie_ic_after_done_latency", 32'(i1 - i0), 32'd13);
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_mem_a"}, mem_a, 32'h0);
    check32({tag, "_mem_dout"}, {24'h0, mem_dout}, 32'h0);
    check32({tag, "_mem_wr"}, {31'h0, mem_wr}, 32'h0);
    check32({tag, "_ic_ack"}, {31'h0, IC_ack}, 32'h0);
    check32({tag, "_ic_data"}, IC_data, 32'h0);
    check32({tag, "_ls_ack"}, {31'h0, LS_ack}, 32'h0);
    check32({tag, "_ls_rdata"}, LS_rdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, s0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]   <= 8'(i * 37 + 11);
      model[i] = 8'(i * 37 + 11);
    end
    ram[4] <= 8'h13; ram[5] <= 8'h00; ram[6] <= 8'h00; ram[7] <= 8'h00;
    model[4] = 8'h13; model[5] = 8'h00; model[6] = 8'h00; model[7] = 8'h00;

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    IC_req_valid = 1'b0; IC_addr = 32'h0;
    LS_req_valid = 1'b0; LS_is_store = 1'b0; LS_size = 2'b00;
    LS_addr = 32'h0; LS_wdata = 32'h0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Word fetch at 4: addresses 4..7 in consecutive cycles, ack 6 cycles after grant.
    fork
      ic_fetch(32'h4, t0, t1);
      begin
        @(posedge clk);
        @(negedge clk);
        for (int j = 1; j <= 5; j++) begin
          @(negedge clk);
          check32("fetch_addr_seq", mem_a, (j <= 4) ? 32'(3 + j) : 32'h0);
        end
      end
    join
    check32("fetch_latency", 32'(t1 - t0), 32'd6);

    tie_round(32'h8);
    tie_round(32'hC);

    ls_op(1'b1, 2'b01, 32'h1FF, 32'h0000BEEF, t0, t1);
    check32("store_half_latency", 32'(t1 - t0), 32'd3);

    // IO store held off by a full UART buffer for five cycles.
    io_buffer_full = 1'b1;
    fork
      ls_op(1'b1, 2'b00, 32'h30000, 32'h41, t0, t1);
      begin
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 io_buffer_full = 1'b0;
      end
    join
    check32("io_write_cycle", 32'(wr_cyc - t0), 32'd6);
    check32("io_store_latency", 32'(t1 - t0), 32'd7);

    // Flush two cycles into a fetch aborts it; the held request is then re-granted.
    @(posedge clk); #1;
    IC_addr = 32'h40;
    IC_req_valid = 1'b1;
    s0 = cyc;
    @(posedge clk);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check32("flush_idle_addr", mem_a, 32'h0);
    check32("flush_idle_wr", {31'h0, mem_wr}, 32'h0);
    begin
      logic [31:0] e;
      for (int k = 0; k < 4; k++) e[8*k +: 8] = model[16'(32'h40 + 32'(k))];
      ic_q.push_back(e);
    end
    t1 = -1;
    for (int n = 0; n < 300; n++) begin
      if (IC_ack) begin
        t1 = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t1 < 0) fail_now("flush_refetch_timeout");
    check32("flush_refetch_latency", 32'(t1 - s0), 32'd9);
    @(posedge clk); #1 IC_req_valid = 1'b0;

    // Flush during a word store does not abort it.
    fork
      ls_op(1'b1, 2'b10, 32'h1040, 32'hCAFEF00D, t0, t1);
      begin
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
      end
    join
    check32("flush_store_latency", 32'(t1 - t0), 32'd5);
    ls_op(1'b0, 2'b10, 32'h1040, 32'h0, t0, t1);

    // Asynchronous reset in the middle of a fetch.
    @(posedge clk); #1;
    IC_addr = 32'h80;
    IC_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    IC_req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    tie_round(32'h10);

    // Randomized contention with rdy and io_buffer_full toggling.
    fork
      begin
        fork
          begin : ic_rand
            int a0, a1;
            repeat (30) begin
              repeat ($urandom_range(0, 3)) @(posedge clk);
              ic_fetch({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, a0, a1);
            end
          end
          begin : ls_rand
            int b0, b1;
            logic st;
            logic [1:0] sz;
            logic [31:0] a;
            repeat (50) begin
              repeat ($urandom_range(0, 3)) @(posedge clk);
              st = 1'($urandom_range(0, 1));
              sz = 2'($urandom_range(0, 2));
              if (st && ($urandom_range(0, 4) == 0)) a = 32'h30000 + 32'($urandom_range(0, 255));
              else a = 32'h1000 + 32'($urandom_range(0, 4095));
              ls_op(st, sz, a, $urandom, b0, b1);
            end
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rdy = ($urandom_range(0, 3) != 0);
          io_buffer_full = ($urandom_range(0, 2) == 0);
        end
        rdy = 1'b1;
        io_buffer_full = 1'b0;
      end
    join

    repeat (5) @(posedge clk);
    check32("ic_queue_drained", 32'(ic_q.size()), 32'd0);
    check32("ls_queue_drained", 32'(ls_q.size()), 32'd0);
    check32("write_queue_drained", 32'(wr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
